// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the multicycle control unit and the memory port.
// The control unit is the master; the memory model is the slave.
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic mem_ready;
  logic iord;

  modport master (output mem_req, output mem_read, output mem_write, output iord,
                  input mem_ready);
  modport slave  (input mem_req, input mem_read, input mem_write, input iord,
                  output mem_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// Control FSM for a multicycle RV32I datapath: FETCH/DECODE/EXEC/MEM/WB sequencing,
// valid/ready memory handshake, illegal-encoding and memory-timeout traps, retire counter.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR, PC <= PC + 4
// DECODE | branch/jump target into ALUOut, legality check
// EXEC   | ALU operation per instruction class
// MEM    | load/store data access at ALUOut
// WB     | register file write
// TRAP   | fault latched, control outputs idle until reset
module multicycle_control_unit #(
  parameter bit          ENABLE_JAL   = 1'b1,
  parameter bit          ENABLE_LUI   = 1'b1,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [6:0]                  opcode,
  input  logic [2:0]                  funct3,
  input  logic [6:0]                  funct7,
  multicycle_control_unit_if.master   mem,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        branch,
  output logic                        pc_src,
  output logic [1:0]                  alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [1:0]                  alu_op,
  output logic [1:0]                  mem_to_reg,
  output logic                        reg_write,
  output logic                        instr_retired,
  output logic [RETIRE_CNT_W-1:0]     retire_count,
  output logic                        trap,
  output logic [1:0]                  trap_cause,
  output logic [2:0]                  state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Counter only needs to hold MEM_TIMEOUT-1: the trap fires on the wait cycle that would reach the limit.
  localparam int unsigned     WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t                  state;
  state_t                  next_state;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [RETIRE_CNT_W-1:0] retire_q;
  logic [1:0]              cause_q;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_lui;
  logic illegal;
  logic waiting;
  logic timeout_hit;

  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_ld  = (opcode == OP_LD);
  assign is_st  = (opcode == OP_ST);
  assign is_br  = (opcode == OP_BR);
  assign is_jal = ENABLE_JAL && (opcode == OP_JAL);
  assign is_lui = ENABLE_LUI && (opcode == OP_LUI);

  assign illegal =
      !(is_r || is_i || is_ld || is_st || is_br || is_jal || is_lui)
    || (is_r && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))
    || (is_r && (funct7 == 7'b0100000) && (funct3 != 3'b000) && (funct3 != 3'b101))
    || (is_ld && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)))
    || (is_st && (funct3 > 3'b010))
    || (is_br && ((funct3 == 3'b010) || (funct3 == 3'b011)));

  assign waiting     = ((state == S_FETCH) || (state == S_MEM)) && !mem.mem_ready;
  assign timeout_hit = TIMEOUT_EN && waiting && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      retire_q <= '0;
      cause_q  <= 2'b00;
    end else begin
      state    <= next_state;
      wait_cnt <= (waiting && (next_state == state)) ? wait_cnt + 1'b1 : '0;
      if (instr_retired)
        retire_q <= retire_q + 1'b1;
      if ((state != S_TRAP) && (next_state == S_TRAP))
        cause_q <= (state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
    end
  end

  // Every output stays at zero while reset is held, so an abandoned access issues nothing.
  always_comb begin
    next_state     = state;
    mem.mem_req    = 1'b0;
    mem.mem_read   = 1'b0;
    mem.mem_write  = 1'b0;
    mem.iord       = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    branch         = 1'b0;
    pc_src         = 1'b0;
    alu_src_a      = 2'b00;
    alu_src_b      = 2'b00;
    alu_op         = 2'b00;
    mem_to_reg     = 2'b00;
    reg_write      = 1'b0;
    instr_retired  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem.mem_req  = 1'b1;
          mem.mem_read = 1'b1;
          if (mem.mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'b01;
            next_state = S_DECODE;
          end else if (timeout_hit) begin
            next_state = S_TRAP;
          end
        end
        S_DECODE: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b10;
          next_state = illegal ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          if (is_r) begin
            alu_src_a  = 2'b01;
            alu_op     = 2'b10;
            next_state = S_WB;
          end else if (is_i) begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            alu_op     = 2'b11;
            next_state = S_WB;
          end else if (is_ld || is_st) begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            next_state = S_MEM;
          end else if (is_br) begin
            alu_src_a     = 2'b01;
            alu_op        = 2'b01;
            branch        = 1'b1;
            pc_src        = 1'b1;
            instr_retired = 1'b1;
            next_state    = S_FETCH;
          end else if (is_jal) begin
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            next_state = S_WB;
          end else if (is_lui) begin
            alu_src_a  = 2'b11;
            alu_src_b  = 2'b10;
            next_state = S_WB;
          end else begin
            next_state = S_FETCH;
          end
        end
        S_MEM: begin
          mem.mem_req   = 1'b1;
          mem.iord      = 1'b1;
          mem.mem_read  = is_ld;
          mem.mem_write = is_st;
          if (mem.mem_ready) begin
            if (is_ld) begin
              next_state = S_WB;
            end else begin
              instr_retired = 1'b1;
              next_state    = S_FETCH;
            end
          end else if (timeout_hit) begin
            next_state = S_TRAP;
          end
        end
        S_WB: begin
          reg_write     = 1'b1;
          mem_to_reg    = is_ld ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
          instr_retired = 1'b1;
          next_state    = S_FETCH;
        end
        S_TRAP: begin
          next_state = S_TRAP;
        end
        default: begin
          next_state = S_FETCH;
        end
      endcase
    end
  end

  assign trap         = !rst && (state == S_TRAP);
  assign trap_cause   = rst ? 2'b00 : cause_q;
  assign retire_count = rst ? '0 : retire_q;
  assign state_dbg    = rst ? 3'd0 : state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each scenario queues the expected per-cycle control vector and
// checks it against the DUT at the falling edge; a second instance has JAL disabled.
module tb_multicycle_control_unit;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_LUI = 6, K_ILL = 7;

  logic clk = 1'b0;
  logic rst;
  logic ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  logic [23:0] sb[$];
  logic        rq[$];
  logic [2:0]  sbb[$];
  logic [23:0] got, want;
  logic [2:0]  want_b;

  multicycle_control_unit_if bus_a ();
  multicycle_control_unit_if bus_b ();
  assign bus_a.mem_ready = ready;
  assign bus_b.mem_ready = ready;

  logic ir_write, pc_write, branch, pc_src, reg_write, instr_retired, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op, mem_to_reg, trap_cause;
  logic [2:0] state_dbg;
  logic [3:0] retire_count;

  logic ir_write_b, pc_write_b, branch_b, pc_src_b, reg_write_b, instr_retired_b, trap_b;
  logic [1:0] alu_src_a_b, alu_src_b_b, alu_op_b, mem_to_reg_b, trap_cause_b;
  logic [2:0] state_dbg_b;
  logic [31:0] retire_count_b;

  multicycle_control_unit #(.ENABLE_JAL(1'b1), .ENABLE_LUI(1'b1), .MEM_TIMEOUT(4), .RETIRE_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .mem(bus_a),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instr_retired(instr_retired), .retire_count(retire_count),
    .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg));

  multicycle_control_unit #(.ENABLE_JAL(1'b0)) dut_nj (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .mem(bus_b),
    .ir_write(ir_write_b), .pc_write(pc_write_b), .branch(branch_b), .pc_src(pc_src_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b), .mem_to_reg(mem_to_reg_b),
    .reg_write(reg_write_b), .instr_retired(instr_retired_b), .retire_count(retire_count_b),
    .trap(trap_b), .trap_cause(trap_cause_b), .state_dbg(state_dbg_b));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1);
  end

  function automatic logic [23:0] obs_a();
    return {state_dbg, bus_a.mem_req, bus_a.mem_read, bus_a.mem_write, bus_a.iord,
            ir_write, pc_write, branch, pc_src, alu_src_a, alu_src_b, alu_op,
            mem_to_reg, reg_write, instr_retired, trap, trap_cause};
  endfunction

  // Expected control vector for a state, instruction class and mem_ready value.
  function automatic logic [23:0] ev(input int st, input int kind, input logic rdy, input logic [1:0] cause);
    logic [2:0] s;
    logic req, rd, wr, io, irw, pcw, br, pcs, rw, ret, tr;
    logic [1:0] a, b, op, m2r;
    s = 3'(st);
    req = 0; rd = 0; wr = 0; io = 0; irw = 0; pcw = 0; br = 0; pcs = 0; rw = 0; ret = 0; tr = 0;
    a = 2'b00; b = 2'b00; op = 2'b00; m2r = 2'b00;
    case (st)
      0: begin req = 1; rd = 1; if (rdy) begin irw = 1; pcw = 1; b = 2'b01; end end
      1: begin a = 2'b10; b = 2'b10; end
      2: case (kind)
           K_R:        begin a = 2'b01; op = 2'b10; end
           K_I:        begin a = 2'b01; b = 2'b10; op = 2'b11; end
           K_LD, K_ST: begin a = 2'b01; b = 2'b10; end
           K_BR:       begin a = 2'b01; op = 2'b01; br = 1; pcs = 1; ret = 1; end
           K_JAL:      begin pcw = 1; pcs = 1; end
           K_LUI:      begin a = 2'b11; b = 2'b10; end
           default: ;
         endcase
      3: begin req = 1; io = 1; rd = (kind == K_LD); wr = (kind == K_ST); ret = (kind == K_ST) && rdy; end
      4: begin rw = 1; ret = 1; m2r = (kind == K_LD) ? 2'b01 : ((kind == K_JAL) ? 2'b10 : 2'b00); end
      5: tr = 1;
      default: ;
    endcase
    return {s, req, rd, wr, io, irw, pcw, br, pcs, a, b, op, m2r, rw, ret, tr, cause};
  endfunction

  task automatic push(input int st, input int kind, input logic rdy, input logic [1:0] cause);
    sb.push_back(ev(st, kind, rdy, cause));
    rq.push_back(rdy);
  endtask

  task automatic push_instr(input int kind);
    push(0, kind, 1'b1, 2'b00);
    push(1, kind, 1'b1, 2'b00);
    push(2, kind, 1'b1, 2'b00);
    if (kind == K_LD || kind == K_ST) push(3, kind, 1'b1, 2'b00);
    if (kind != K_BR && kind != K_ST) push(4, kind, 1'b1, 2'b00);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
  endtask

  task automatic reset_dut();
    rst = 1'b1; ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1;
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== 24'h0 || retire_count !== 4'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h/%0d want=000000/0", i, obs_a(), retire_count);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 3'd0 || bus_a.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL first_fetch got state=%0d req=%b want state=0 req=1", state_dbg, bus_a.mem_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r_add();
    reset_dut();
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    push_instr(K_R);
    while (sb.size() > 0) begin
      ready = rq.pop_front();
      @(negedge clk);
      got = obs_a(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL r_add got=%h want=%h", got, want); end
      @(posedge clk); #1;
    end
    checks++;
    if (retire_count !== 4'd1) begin errors++; $display("FAIL r_add_retire got=%0d want=1", retire_count); end
  endtask

  task automatic test_load_wait();
    reset_dut();
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    push(0, K_LD, 1'b1, 2'b00); push(1, K_LD, 1'b1, 2'b00); push(2, K_LD, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) push(3, K_LD, 1'b0, 2'b00);
    push(3, K_LD, 1'b1, 2'b00); push(4, K_LD, 1'b1, 2'b00);
    while (sb.size() > 0) begin
      ready = rq.pop_front();
      @(negedge clk);
      got = obs_a(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL load_wait got=%h want=%h", got, want); end
      @(posedge clk); #1;
    end
    checks++;
    if (retire_count !== 4'd1) begin errors++; $display("FAIL load_retire got=%0d want=1", retire_count); end
  endtask

  task automatic test_branch();
    reset_dut();
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    push_instr(K_BR);
    push(0, K_BR, 1'b0, 2'b00);
    while (sb.size() > 0) begin
      ready = rq.pop_front();
      @(negedge clk);
      got = obs_a(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL beq got=%h want=%h", got, want); end
      @(posedge clk); #1;
    end
    checks++;
    if (retire_count !== 4'd1) begin errors++; $display("FAIL beq_retire got=%0d want=1", retire_count); end
  endtask

  task automatic test_classes();
    logic [6:0] ops [6] = '{7'b0010011, 7'b0100011, 7'b1101111, 7'b0110111, 7'b0110011, 7'b0110011};
    logic [2:0] f3s [6] = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b101};
    logic [6:0] f7s [6] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h20};
    int         kinds [6] = '{K_I, K_ST, K_JAL, K_LUI, K_R, K_R};
    reset_dut();
    for (int n = 0; n < 6; n++) begin
      set_instr(ops[n], f3s[n], f7s[n]);
      push_instr(kinds[n]);
      while (sb.size() > 0) begin
        ready = rq.pop_front();
        @(negedge clk);
        got = obs_a(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL class_%0d got=%h want=%h", n, got, want); end
        @(posedge clk); #1;
      end
    end
    checks++;
    if (retire_count !== 4'd6) begin errors++; $display("FAIL class_retire got=%0d want=6", retire_count); end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [8] = '{7'b0110011, 7'b0110011, 7'b0000011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0000000, 7'b1110011};
    logic [2:0] f3s [8] = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b011, 3'b010, 3'b000, 3'b000};
    logic [6:0] f7s [8] = '{7'h01, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    for (int n = 0; n < 8; n++) begin
      reset_dut();
      set_instr(ops[n], f3s[n], f7s[n]);
      push(0, K_ILL, 1'b1, 2'b00); push(1, K_ILL, 1'b1, 2'b00);
      for (int i = 0; i < ((n == 0) ? 20 : 2); i++) push(5, K_ILL, 1'b1, 2'b01);
      while (sb.size() > 0) begin
        ready = rq.pop_front();
        @(negedge clk);
        got = obs_a(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL illegal_%0d got=%h want=%h", n, got, want); end
        @(posedge clk); #1;
      end
      reset_dut();
      ready = 1'b0;
      @(negedge clk);
      checks++;
      if (trap !== 1'b0 || state_dbg !== 3'd0 || trap_cause !== 2'b00) begin
        errors++;
        $display("FAIL illegal_clear_%0d got trap=%b st=%0d cause=%b want 0/0/00", n, trap, state_dbg, trap_cause);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal_disabled();
    reset_dut();
    set_instr(7'b1101111, 3'b000, 7'b0000000);
    push_instr(K_JAL);
    sbb.push_back(3'd0); sbb.push_back(3'd1); sbb.push_back(3'd5); sbb.push_back(3'd5);
    while (sb.size() > 0) begin
      ready = rq.pop_front();
      @(negedge clk);
      got = obs_a(); want = sb.pop_front(); want_b = sbb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL jal_enabled got=%h want=%h", got, want); end
      checks++;
      if (state_dbg_b !== want_b || trap_b !== (want_b == 3'd5) || trap_cause_b !== ((want_b == 3'd5) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL jal_disabled got st=%0d trap=%b cause=%b want st=%0d", state_dbg_b, trap_b, trap_cause_b, want_b);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    for (int i = 0; i < 4; i++) push(0, K_R, 1'b0, 2'b00);
    push(5, K_R, 1'b0, 2'b10); push(5, K_R, 1'b1, 2'b10);
    while (sb.size() > 0) begin
      ready = rq.pop_front();
      @(negedge clk);
      got = obs_a(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL fetch_timeout got=%h want=%h", got, want); end
      @(posedge clk); #1;
    end
    reset_dut();
    for (int i = 0; i < 3; i++) push(0, K_R, 1'b0, 2'b00);
    push(0, K_R, 1'b1, 2'b00); push(1, K_R, 1'b1, 2'b00); push(2, K_R, 1'b1, 2'b00); push(4, K_R, 1'b1, 2'b00);
    while (sb.size() > 0) begin
      ready = rq.pop_front();
      @(negedge clk);
      got = obs_a(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL ready_at_limit got=%h want=%h", got, want); end
      @(posedge clk); #1;
    end
    reset_dut();
    set_instr(7'b0000011, 3'b000, 7'b0000000);
    push(0, K_LD, 1'b1, 2'b00); push(1, K_LD, 1'b1, 2'b00); push(2, K_LD, 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) push(3, K_LD, 1'b0, 2'b00);
    push(5, K_LD, 1'b1, 2'b10);
    while (sb.size() > 0) begin
      ready = rq.pop_front();
      @(negedge clk);
      got = obs_a(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL mem_timeout got=%h want=%h", got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    set_instr(7'b0010011, 3'b000, 7'b0000000);
    for (int n = 0; n < 17; n++) begin
      push_instr(K_I);
      while (sb.size() > 0) begin
        ready = rq.pop_front();
        @(negedge clk);
        got = obs_a(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL addi_%0d got=%h want=%h", n, got, want); end
        @(posedge clk); #1;
      end
      exp_cnt = (exp_cnt + 1) % 16;
      checks++;
      if (retire_count !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL retire_wrap_%0d got=%0d want=%0d", n, retire_count, exp_cnt);
      end
    end
  endtask

  task automatic test_rst_mid_store();
    reset_dut();
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    push_instr(K_R);
    while (sb.size() > 0) begin
      ready = rq.pop_front();
      @(negedge clk);
      got = obs_a(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pre_store got=%h want=%h", got, want); end
      @(posedge clk); #1;
    end
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    push(0, K_ST, 1'b1, 2'b00); push(1, K_ST, 1'b1, 2'b00); push(2, K_ST, 1'b1, 2'b00);
    push(3, K_ST, 1'b0, 2'b00); push(3, K_ST, 1'b0, 2'b00);
    while (sb.size() > 0) begin
      ready = rq.pop_front();
      @(negedge clk);
      got = obs_a(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL sw_wait got=%h want=%h", got, want); end
      @(posedge clk); #1;
    end
    rst = 1'b1; ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus_a.mem_write !== 1'b0 || obs_a() !== 24'h0 || retire_count !== 4'd0) begin
        errors++;
        $display("FAIL rst_mid_sw cyc=%0d got wr=%b vec=%h cnt=%0d want 0/000000/0", i, bus_a.mem_write, obs_a(), retire_count);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 3'd0 || bus_a.mem_write !== 1'b0 || retire_count !== 4'd0) begin
      errors++;
      $display("FAIL after_rst_mid got st=%0d wr=%b cnt=%0d want 0/0/0", state_dbg, bus_a.mem_write, retire_count);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0;
    opcode = 7'b0; funct3 = 3'b0; funct7 = 7'b0;
    test_reset();
    test_r_add();
    test_load_wait();
    test_branch();
    test_classes();
    test_illegal();
    test_jal_disabled();
    test_timeout();
    test_back_to_back();
    test_rst_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
